// File: rtl/serdes_gt_tx_sched_if.sv
// Link bus of the GT TX scheduler: two frame requesters in, one GT TX word out.
// "slave" is the scheduler's view; "master" is the view of whatever drives the requesters.
interface serdes_gt_tx_sched_if;
    // Requester A
    logic [15:0] A_DATA_IN;
    logic [1:0]  A_CTRL_IN;
    logic        A_VALID_IN;
    logic        A_LAST_IN;
    logic        A_READY_OUT;
    // Requester B (test-pattern frame generator)
    logic [15:0] B_DATA_IN;
    logic [1:0]  B_CTRL_IN;
    logic        B_VALID_IN;
    logic        B_LAST_IN;
    logic        B_READY_OUT;
    // GT TX side and status
    logic [15:0] TX_DATA_OUT;
    logic [1:0]  TXCTRL_OUT;
    logic        TX_ALIGNED_OUT;
    logic [1:0]  GRANT_OUT;

    modport slave (
        input  A_DATA_IN, A_CTRL_IN, A_VALID_IN, A_LAST_IN,
        input  B_DATA_IN, B_CTRL_IN, B_VALID_IN, B_LAST_IN,
        output A_READY_OUT, B_READY_OUT,
        output TX_DATA_OUT, TXCTRL_OUT, TX_ALIGNED_OUT, GRANT_OUT
    );

    modport master (
        output A_DATA_IN, A_CTRL_IN, A_VALID_IN, A_LAST_IN,
        output B_DATA_IN, B_CTRL_IN, B_VALID_IN, B_LAST_IN,
        input  A_READY_OUT, B_READY_OUT,
        input  TX_DATA_OUT, TXCTRL_OUT, TX_ALIGNED_OUT, GRANT_OUT
    );
endinterface

// File: rtl/serdes_gt_tx_sched.sv
// GT TX word scheduler: sends ALIGN_WORDS comma/idle words after reset, then
// arbitrates two framed requesters round-robin per frame, inserting idle words
// when nothing is sent.
// Optional feature macro: SERDES_TX_CC_EN -- when defined, a burst of CC_LEN
// clock-correction words preempts the link every CC_PERIOD RUN cycles.
module serdes_gt_tx_sched #(
    parameter int unsigned ALIGN_WORDS = 64,
    parameter int unsigned CC_PERIOD   = 5000,
    parameter int unsigned CC_LEN      = 4
) (
    input logic                 USER_CLK,
    input logic                 SYSTEM_RESET,
    serdes_gt_tx_sched_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_DATA = 16'h50BC;  // K28.5 in the low byte
    localparam logic [1:0]  IDLE_CTRL = 2'b01;
    localparam logic [15:0] CC_DATA   = 16'hF7F7;
    localparam logic [1:0]  CC_CTRL   = 2'b11;

    localparam int AW = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    // A bad configuration is caught at elaboration rather than producing a link that never aligns.
    if (ALIGN_WORDS == 0 || CC_LEN == 0 || CC_LEN >= CC_PERIOD) begin : g_bad_cfg
        $error("serdes_gt_tx_sched: need ALIGN_WORDS >= 1 and 1 <= CC_LEN < CC_PERIOD");
    end

    state_t        state;
    logic [AW-1:0] align_cnt;
    logic [1:0]    grant;
    logic          prefer_b;   // round-robin pointer: 1 when B is next in line
    logic [15:0]   tx_data;
    logic [1:0]    tx_ctrl;
    logic          aligned;
    logic          cc_busy;    // the word loaded at the end of this cycle is a CC word
    logic          xfer_a;
    logic          xfer_b;

`ifdef SERDES_TX_CC_EN
    localparam int CW = $clog2(CC_PERIOD);
    localparam int LW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;

    logic [CW-1:0] cc_cnt;     // RUN cycle index modulo CC_PERIOD
    logic [LW-1:0] cc_left;    // CC words still owed after the first one of a burst
    logic          cc_start;

    assign cc_start = (state == ST_RUN) && (cc_cnt == CW'(CC_PERIOD - 1));
    assign cc_busy  = cc_start || (cc_left != '0);

    // Clock-correction timer: counts RUN cycles and tracks the remainder of a burst.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            cc_cnt  <= '0;
            cc_left <= '0;
        end else if (state == ST_RUN) begin
            if (cc_start) begin
                cc_cnt  <= '0;
                cc_left <= LW'(CC_LEN - 1);
            end else begin
                cc_cnt <= cc_cnt + 1'b1;
                if (cc_left != '0) begin
                    cc_left <= cc_left - 1'b1;
                end
            end
        end
    end
`else
    assign cc_busy = 1'b0;
`endif

    // READY is a pure decode of registered state so it never combinationally follows VALID;
    // it drops for exactly the cycles whose outgoing word is a CC word.
    assign bus.A_READY_OUT = (state == ST_RUN) && (grant == GRANT_A) && !cc_busy;
    assign bus.B_READY_OUT = (state == ST_RUN) && (grant == GRANT_B) && !cc_busy;

    assign xfer_a = bus.A_VALID_IN && bus.A_READY_OUT;
    assign xfer_b = bus.B_VALID_IN && bus.B_READY_OUT;

    // Link FSM with registered word output, grant and round-robin pointer.
    always_ff @(posedge USER_CLK) begin
        // NOTE: every register here updates with <= so all of them see the pre-edge
        // values of each other, exactly like the flops they become.
        if (SYSTEM_RESET) begin
            state     <= ST_RESET;
            align_cnt <= '0;
            grant     <= GRANT_NONE;
            prefer_b  <= 1'b0;
            tx_data   <= 16'h0000;
            tx_ctrl   <= 2'b00;
            aligned   <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state   <= ST_ALIGN;
                    tx_data <= IDLE_DATA;
                    tx_ctrl <= IDLE_CTRL;
                end

                ST_ALIGN: begin
                    tx_data <= IDLE_DATA;
                    tx_ctrl <= IDLE_CTRL;
                    if (align_cnt == AW'(ALIGN_WORDS - 1)) begin
                        state   <= ST_RUN;
                        aligned <= 1'b1;
                    end else begin
                        align_cnt <= align_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (cc_busy) begin
                        tx_data <= CC_DATA;
                        tx_ctrl <= CC_CTRL;
                    end else if (xfer_a) begin
                        tx_data <= bus.A_DATA_IN;
                        tx_ctrl <= bus.A_CTRL_IN;
                    end else if (xfer_b) begin
                        tx_data <= bus.B_DATA_IN;
                        tx_ctrl <= bus.B_CTRL_IN;
                    end else begin
                        tx_data <= IDLE_DATA;
                        tx_ctrl <= IDLE_CTRL;
                    end

                    // Grant is released by the owner's LAST word and only re-issued from
                    // the no-owner state, which forces one idle word between frames.
                    if ((xfer_a && bus.A_LAST_IN) || (xfer_b && bus.B_LAST_IN)) begin
                        grant <= GRANT_NONE;
                    end else if (grant == GRANT_NONE && !cc_busy) begin
                        if (bus.A_VALID_IN && (!bus.B_VALID_IN || !prefer_b)) begin
                            grant    <= GRANT_A;
                            prefer_b <= 1'b1;
                        end else if (bus.B_VALID_IN) begin
                            grant    <= GRANT_B;
                            prefer_b <= 1'b0;
                        end
                    end
                end

                default: state <= ST_RESET;
            endcase
        end
    end

    assign bus.TX_DATA_OUT    = tx_data;
    assign bus.TXCTRL_OUT     = tx_ctrl;
    assign bus.TX_ALIGNED_OUT = aligned;
    assign bus.GRANT_OUT      = grant;

endmodule

// File: tb/tb_serdes_gt_tx_sched.sv
// Self-checking bench for serdes_gt_tx_sched: a frame-level behavioural model
// predicts every output each cycle; directed sections pin alignment length,
// frame latency, round-robin order and mid-frame reset with literal values.
module tb_serdes_gt_tx_sched;

    localparam int ALIGN_WORDS = 64;
    localparam int CC_PERIOD   = 16;
    localparam int CC_LEN      = 4;
`ifdef SERDES_TX_CC_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serdes_gt_tx_sched_if bus ();

    serdes_gt_tx_sched #(
        .ALIGN_WORDS (ALIGN_WORDS),
        .CC_PERIOD   (CC_PERIOD),
        .CC_LEN      (CC_LEN)
    ) dut (
        .USER_CLK     (clk),
        .SYSTEM_RESET (rst),
        .bus          (bus)
    );

    int tests = 0;
    int fails = 0;
    int cc_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_since counts clock edges since reset was released. The link is in RUN once
    // more than ALIGN_WORDS such edges have passed; the RUN cycle index is then
    // m_since - ALIGN_WORDS - 1, and CC slots follow from that index arithmetically.
    int          m_since = 0;
    int          m_owner = 0;      // 0 none, 1 A, 2 B
    int          m_prefer = 1;     // requester favoured when both are valid
    bit          m_xfer [2];
    bit          model_valid = 1'b0;
    logic [15:0] exp_data;
    logic [1:0]  exp_ctrl;
    logic [1:0]  exp_grant;
    logic        exp_aligned = 1'b0;
    logic        exp_ready_a = 1'b0;
    logic        exp_ready_b = 1'b0;
    bit          was_run, cc_prev, cur_cc, xa, xb;

    function automatic bit cc_slot(input int idx);
        return CC_ON && idx >= CC_PERIOD - 1 && ((idx - (CC_PERIOD - 1)) % CC_PERIOD) < CC_LEN;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_since = 0; m_owner = 0; m_prefer = 1;
            exp_data = 16'h0000; exp_ctrl = 2'b00; exp_grant = 2'b00;
            exp_aligned = 1'b0; exp_ready_a = 1'b0; exp_ready_b = 1'b0;
            m_xfer[0] = 1'b0; m_xfer[1] = 1'b0;
        end else begin
            was_run = exp_aligned;
            cc_prev = was_run && cc_slot(m_since - ALIGN_WORDS - 1);
            xa = exp_ready_a && bus.A_VALID_IN;
            xb = exp_ready_b && bus.B_VALID_IN;
            if (cc_prev) begin
                exp_data = 16'hF7F7; exp_ctrl = 2'b11;
            end else if (xa) begin
                exp_data = bus.A_DATA_IN; exp_ctrl = bus.A_CTRL_IN;
            end else if (xb) begin
                exp_data = bus.B_DATA_IN; exp_ctrl = bus.B_CTRL_IN;
            end else begin
                exp_data = 16'h50BC; exp_ctrl = 2'b01;
            end
            if ((xa && bus.A_LAST_IN) || (xb && bus.B_LAST_IN)) begin
                m_owner = 0;
            end else if (was_run && m_owner == 0 && !cc_prev) begin
                if (bus.A_VALID_IN && bus.B_VALID_IN) m_owner = m_prefer;
                else if (bus.A_VALID_IN)              m_owner = 1;
                else if (bus.B_VALID_IN)              m_owner = 2;
                if (m_owner != 0) m_prefer = (m_owner == 1) ? 2 : 1;
            end
            m_xfer[0] = xa;
            m_xfer[1] = xb;
            m_since++;
            exp_aligned = (m_since > ALIGN_WORDS);
            cur_cc      = exp_aligned && cc_slot(m_since - ALIGN_WORDS - 1);
            exp_ready_a = exp_aligned && m_owner == 1 && !cur_cc;
            exp_ready_b = exp_aligned && m_owner == 2 && !cur_cc;
            exp_grant   = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        end
        model_valid = 1'b1;
    end

    // Every cycle, on the falling edge, every output is compared with the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("tx_data",    bus.TX_DATA_OUT,    exp_data);
            check("txctrl",     bus.TXCTRL_OUT,     exp_ctrl);
            check("grant",      bus.GRANT_OUT,      exp_grant);
            check("aligned",    bus.TX_ALIGNED_OUT, exp_aligned);
            check("a_ready",    bus.A_READY_OUT,    exp_ready_a);
            check("b_ready",    bus.B_READY_OUT,    exp_ready_b);
            if (bus.TX_DATA_OUT == 16'hF7F7 && bus.TXCTRL_OUT == 2'b11) cc_seen++;
        end
    end

    // ---------------- frame generators ----------------
    int          g_left [2];
    bit          g_on [2];
    logic [15:0] g_seq [2];

    task automatic gen_reset();
        for (int r = 0; r < 2; r++) begin
            g_left[r] = 0; g_on[r] = 1'b0; g_seq[r] = 16'h0000;
        end
    endtask

    task automatic gen_drive();
        bus.A_VALID_IN = g_on[0];
        bus.A_DATA_IN  = {4'hA, g_seq[0][11:0]};
        bus.A_CTRL_IN  = g_seq[0][13:12];
        bus.A_LAST_IN  = (g_left[0] == 1);
        bus.B_VALID_IN = g_on[1];
        bus.B_DATA_IN  = {4'hB, g_seq[1][11:0]};
        bus.B_CTRL_IN  = g_seq[1][13:12];
        bus.B_LAST_IN  = (g_left[1] == 1);
    endtask

    // mode 0: random frames and gaps; 1: back-to-back 2-word frames; 2: finish current frames only
    task automatic gen_step(input int mode);
        for (int r = 0; r < 2; r++) begin
            if (m_xfer[r] && g_on[r]) begin
                g_seq[r]++;
                g_left[r]--;
                g_on[r] = 1'b0;
            end
            if (!g_on[r]) begin
                if (g_left[r] == 0) begin
                    if (mode == 1)                                   g_left[r] = 2;
                    else if (mode == 0 && $urandom_range(0, 3) != 0) g_left[r] = $urandom_range(1, 4);
                end
                if (g_left[r] != 0) g_on[r] = (mode != 0) || ($urandom_range(0, 3) != 0);
            end
        end
        gen_drive();
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            gen_step(2);
            done = (g_left[0] == 0) && (g_left[1] == 0) && (m_owner == 0);
        end
        check(name, done, 1'b1);
    endtask

    task automatic drive_a(input logic valid, input logic [15:0] data, input logic last);
        bus.A_VALID_IN = valid;
        bus.A_DATA_IN  = data;
        bus.A_CTRL_IN  = 2'b00;
        bus.A_LAST_IN  = last;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0] rr_order [$];
    logic [1:0] rr_exp [4];
    logic [1:0] prev_grant;
    bit         got;

    initial begin
        gen_reset();
        gen_drive();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_all_zero",
              {bus.TX_DATA_OUT, bus.TXCTRL_OUT, bus.GRANT_OUT, bus.TX_ALIGNED_OUT, bus.A_READY_OUT, bus.B_READY_OUT},
              24'h0);
        rst = 1'b0;

        // Exactly ALIGN_WORDS idle words, unaligned, then the link reports aligned.
        for (int i = 0; i < ALIGN_WORDS; i++) begin
            @(negedge clk);
            check("align_idle", {bus.TX_ALIGNED_OUT, bus.TXCTRL_OUT, bus.TX_DATA_OUT}, {1'b0, 2'b01, 16'h50BC});
        end
        @(negedge clk);
        check("aligned_after_64", {bus.TX_ALIGNED_OUT, bus.TXCTRL_OUT, bus.TX_DATA_OUT}, {1'b1, 2'b01, 16'h50BC});

        // A sends 1111, 2222, 3333 starting in the first RUN cycle (well before any CC slot).
        drive_a(1'b1, 16'h1111, 1'b0);
        @(negedge clk);
        check("frame_grant_a", bus.GRANT_OUT, 2'b01);
        check("frame_gap_idle", bus.TX_DATA_OUT, 16'h50BC);
        @(negedge clk);
        check("frame_w1", bus.TX_DATA_OUT, 16'h1111);
        drive_a(1'b1, 16'h2222, 1'b0);
        @(negedge clk);
        check("frame_w2", bus.TX_DATA_OUT, 16'h2222);
        drive_a(1'b1, 16'h3333, 1'b1);
        @(negedge clk);
        check("frame_w3", bus.TX_DATA_OUT, 16'h3333);
        check("frame_release", bus.GRANT_OUT, 2'b00);
        drive_a(1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        check("frame_trailing_idle", {bus.GRANT_OUT, bus.TXCTRL_OUT, bus.TX_DATA_OUT}, {2'b00, 2'b01, 16'h50BC});

        // Both requesters stream 2-word frames. A owned the last frame, so B goes first.
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
        prev_grant = 2'b00;
        for (int c = 0; c < 100 && rr_order.size() < 4; c++) begin
            @(negedge clk);
            if (bus.GRANT_OUT != 2'b00 && prev_grant == 2'b00) rr_order.push_back(bus.GRANT_OUT);
            prev_grant = bus.GRANT_OUT;
            gen_step(1);
        end
        check("rr_frames", rr_order.size(), 4);
        for (int i = 0; i < rr_order.size() && i < 4; i++) check("rr_order", rr_order[i], rr_exp[i]);
        drain("rr_drain");

        // Long randomized traffic run.
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            gen_step(0);
        end
        drain("random_drain");
        if (CC_ON) check("cc_words_present", cc_seen != 0, 1'b1);
        else       check("no_cc_words", cc_seen, 0);

        // B frame aborted by a one-cycle reset while its second word is offered.
        gen_reset();
        gen_drive();
        bus.B_VALID_IN = 1'b1;
        bus.B_DATA_IN  = 16'hB100;
        bus.B_CTRL_IN  = 2'b00;
        bus.B_LAST_IN  = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            got = m_xfer[1];
        end
        check("b_word1_taken", got, 1'b1);
        bus.B_DATA_IN = 16'hB101;
        rst = 1'b1;
        @(negedge clk);
        check("abort_all_zero",
              {bus.TX_DATA_OUT, bus.TXCTRL_OUT, bus.GRANT_OUT, bus.TX_ALIGNED_OUT, bus.B_READY_OUT},
              23'h0);
        rst = 1'b0;
        bus.B_LAST_IN = 1'b1;
        // 64 ALIGN cycles plus the first RUN cycle show no owner; the grant lands one edge later.
        for (int i = 0; i < ALIGN_WORDS + 1; i++) begin
            @(negedge clk);
            check("realign_no_grant", bus.GRANT_OUT, 2'b00);
        end
        @(negedge clk);
        check("regrant_b", bus.GRANT_OUT, 2'b10);
        @(negedge clk);
        check("regrant_b_word", bus.TX_DATA_OUT, 16'hB101);
        bus.B_VALID_IN = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
